// File: rtl/data_mem_responder.sv
// Data-side memory responder: word-organised little-endian RAM answering MREQ with ACKD_n after WAIT cycles.
// Optional macro MEM_ALIGN_CHECK_EN: flag and suppress misaligned accesses instead of forcing alignment.
module data_mem_responder #(
    parameter int ADDR_W = 12,
    parameter int WAIT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MREQ,
    input  logic        WRITE,
    input  logic [1:0]  SIZE,
    input  logic [31:0] DAD,
    inout  wire  [31:0] DDT,
    output logic        ACKD_n,
    output logic        ALIGN_ERR
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAITING = 2'd1;
    localparam logic [1:0] ACK     = 2'd2;
    localparam logic [3:0] WAIT_INIT = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

    logic [1:0]        state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic              write_reg;
    logic [1:0]        size_reg;
    logic [1:0]        lane_reg;
    logic [ADDR_W-1:0] waddr_reg;
    logic [31:0]       wdata_reg;
    logic              mis_reg;

    logic              accept;
    logic [1:0]        lane_in;
    logic              mis_in;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic              commit;
    logic [3:0]        byte_we;
    logic [31:0]       lane_wdata;
    logic [31:0]       load_data;
    logic              unused_dad_hi;

    assign unused_dad_hi = ^DAD[31:ADDR_W+2];
    assign accept = (state_reg == IDLE) && MREQ;

    // Lane used for the access; halfword/word lanes are forced to their aligned position.
    always_comb begin
        lane_in = DAD[1:0];
        if (SIZE == 2'b01) begin
            lane_in = {DAD[1], 1'b0};
        end else if (SIZE != 2'b10) begin
            lane_in = 2'b00;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign mis_in = (SIZE == 2'b01) ? DAD[0] :
                    (SIZE == 2'b10) ? 1'b0 : (DAD[1:0] != 2'b00);
`else
    assign mis_in = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (MREQ) begin
                    state_next = (WAIT == 0) ? ACK : WAITING;
                    cnt_next   = WAIT_INIT;
                end
            end
            WAITING: begin
                if (cnt_reg == 4'd0) begin
                    state_next = ACK;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            write_reg <= WRITE;
            size_reg  <= SIZE;
            lane_reg  <= lane_in;
            waddr_reg <= DAD[ADDR_W+1:2];
            wdata_reg <= DDT;
            mis_reg   <= mis_in;
        end
    end

    // Read every cycle so the word is ready in ACK even when WAIT is zero.
    assign rd_addr = (state_reg == IDLE) ? DAD[ADDR_W+1:2] : waddr_reg;
    assign commit  = rst && (state_reg == ACK) && write_reg && !mis_reg;

    always_comb begin
        byte_we    = 4'b1111;
        lane_wdata = wdata_reg;
        if (size_reg == 2'b10) begin
            byte_we    = 4'b0001 << lane_reg;
            lane_wdata = {4{wdata_reg[7:0]}};
        end else if (size_reg == 2'b01) begin
            byte_we    = lane_reg[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{wdata_reg[15:0]}};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clk) begin
                if (commit && byte_we[gi]) begin
                    mem[waddr_reg] <= lane_wdata[gi*8 +: 8];
                end
                rd_byte_reg <= mem[rd_addr];
            end

            assign rd_data[gi*8 +: 8] = rd_byte_reg;
        end
    endgenerate

    always_comb begin
        load_data = rd_data;
        if (mis_reg) begin
            load_data = 32'h0000_0000;
        end else if (size_reg == 2'b10) begin
            load_data = {24'd0, rd_data[8*lane_reg +: 8]};
        end else if (size_reg == 2'b01) begin
            load_data = lane_reg[1] ? {16'd0, rd_data[31:16]} : {16'd0, rd_data[15:0]};
        end
    end

    assign DDT    = ((state_reg == ACK) && !write_reg) ? load_data : 'z;
    assign ACKD_n = (state_reg != ACK);

`ifdef MEM_ALIGN_CHECK_EN
    logic align_err_reg;

    // Sticky; raised on the edge into ACK so it is already visible in the ACK cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            align_err_reg <= 1'b0;
        end else if ((state_next == ACK) && (accept ? mis_in : mis_reg)) begin
            align_err_reg <= 1'b1;
        end
    end

    assign ALIGN_ERR = align_err_reg;
`else
    assign ALIGN_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: WAIT=2 and WAIT=0 instances checked against a byte-level memory model.
// Honours MEM_ALIGN_CHECK_EN when the same macro is defined for the bench.
`timescale 1ns/1ps
module tb_data_mem_responder;
    localparam int ADDR_W = 12;
    localparam logic [31:0] AMASK = (32'd1 << (ADDR_W + 2)) - 32'd1;
    localparam int BIG = 1 << 30;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mreq [2];
    logic        wr   [2];
    logic [1:0]  sz   [2];
    logic [31:0] dad  [2];
    logic [31:0] drv  [2];
    logic        oe   [2];
    wire         ack0, ack1, aerr0, aerr1;
    wire  [31:0] ddt0, ddt1;

    assign ddt0 = oe[0] ? drv[0] : 'z;
    assign ddt1 = oe[1] ? drv[1] : 'z;

    data_mem_responder #(.ADDR_W(ADDR_W), .WAIT(2)) dut_w2 (
        .clk(clk), .rst(rst), .MREQ(mreq[0]), .WRITE(wr[0]), .SIZE(sz[0]),
        .DAD(dad[0]), .DDT(ddt0), .ACKD_n(ack0), .ALIGN_ERR(aerr0)
    );
    data_mem_responder #(.ADDR_W(ADDR_W), .WAIT(0)) dut_w0 (
        .clk(clk), .rst(rst), .MREQ(mreq[1]), .WRITE(wr[1]), .SIZE(sz[1]),
        .DAD(dad[1]), .DDT(ddt1), .ACKD_n(ack1), .ALIGN_ERR(aerr1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_tests = 0;
    int          n_fail = 0;
    bit          checking = 1'b0;
    int          exp_ack_cyc [2];
    bit          exp_load    [2];
    logic [31:0] exp_data    [2];
    int          aerr_from   [2];
    logic [7:0]  mb0 [int];
    logic [7:0]  mb1 [int];

    function automatic int wt(input int w);
        return (w == 0) ? 2 : 0;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic logic [7:0] mrd(input int w, input int a);
        if (w == 0) return mb0.exists(a) ? mb0[a] : 8'hxx;
        return mb1.exists(a) ? mb1[a] : 8'hxx;
    endfunction

    function automatic void mwr(input int w, input int a, input logic [7:0] v);
        if (w == 0) mb0[a] = v;
        else        mb1[a] = v;
    endfunction

    // Reference: a flat byte memory; an access touches nb consecutive bytes, little-endian.
    function automatic void model_xact(input int w, input bit is_wr, input logic [1:0] s,
                                       input logic [31:0] addr, input logic [31:0] data, input int ackc);
        int nb = (s == 2'b10) ? 1 : (s == 2'b01) ? 2 : 4;
        int a = int'(addr & AMASK);
        bit bad = ((a % nb) != 0);
        logic [31:0] r = 32'h0;
        if (ALIGN_CHK) begin
            if (bad && aerr_from[w] > ackc) aerr_from[w] = ackc;
        end else begin
            a = a - (a % nb);
            bad = 1'b0;
        end
        if (!bad) begin
            for (int k = 0; k < nb; k++) begin
                if (is_wr) mwr(w, a + k, data[8*k +: 8]);
                else       r[8*k +: 8] = mrd(w, a + k);
            end
        end
        exp_ack_cyc[w] = ackc;
        exp_load[w]    = !is_wr;
        exp_data[w]    = r;
    endfunction

    // Called at the falling edge of a cycle in which the addressed instance is idle.
    task automatic xact(input int w, input bit is_wr, input logic [1:0] s, input logic [31:0] addr,
                        input logic [31:0] data, output logic [31:0] rdata, output int lat);
        int c0 = cyc;
        int ackc = cyc + wt(w) + 1;
        mreq[1-w] = 1'b0;
        oe[1-w]   = 1'b0;
        mreq[w] = 1'b1; wr[w] = is_wr; sz[w] = s; dad[w] = addr; drv[w] = data; oe[w] = is_wr;
        model_xact(w, is_wr, s, addr, data, ackc);
        $display("[TB] dut%0d %s size=%b addr=%h data=%h ack_cycle=%0d", w, is_wr ? "ST" : "LD",
                 s, addr, is_wr ? data : exp_data[w], ackc);
        rdata = 'x;
        lat = -1;
        for (int i = 1; i <= wt(w) + 1; i++) begin
            @(negedge clk);
            if (lat < 0 && ((w == 0) ? ack0 : ack1) == 1'b0) lat = cyc - c0;
            if (i == wt(w) + 1) rdata = (w == 0) ? ddt0 : ddt1;
            dad[w] = $urandom; sz[w] = 2'($urandom); drv[w] = $urandom;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int w = 0; w < 2; w++) begin
            mreq[w] = 1'b0; oe[w] = 1'b0; dad[w] = $urandom;
        end
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b0;
        for (int w = 0; w < 2; w++) begin
            mreq[w] = 1'b0; oe[w] = 1'b0; exp_ack_cyc[w] = -1; aerr_from[w] = BIG;
        end
        repeat (n) @(negedge clk);
    endtask

    // Every cycle: ACKD_n, DDT ownership/data and ALIGN_ERR against the model's expectations.
    always @(posedge clk) begin
        #1;
        if (checking) begin
            for (int w = 0; w < 2; w++) begin
                logic        a_n;
                logic        ae;
                logic [31:0] bus;
                bit          exp_ack;
                a_n = (w == 0) ? ack0 : ack1;
                ae  = (w == 0) ? aerr0 : aerr1;
                bus = (w == 0) ? ddt0 : ddt1;
                exp_ack = (cyc == exp_ack_cyc[w]);
                check($sformatf("ackd_n_dut%0d", w), {31'd0, a_n}, {31'd0, !exp_ack});
                if (exp_ack && exp_load[w]) begin
                    check($sformatf("load_data_dut%0d", w), bus, exp_data[w]);
                end else if (oe[w]) begin
                    check($sformatf("ddt_core_drive_dut%0d", w), bus, drv[w]);
                end else begin
                    n_tests++;
                    if (!(bus === 32'bz || bus === 32'h0)) begin
                        n_fail++;
                        $display("FAIL ddt_hiz_dut%0d: got %h, required high-Z (cycle %0d)", w, bus, cyc);
                    end
                end
                check($sformatf("align_err_dut%0d", w), {31'd0, ae}, {31'd0, cyc >= aerr_from[w]});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        int          c0;
        int          acks [4];

        for (int w = 0; w < 2; w++) begin
            wr[w] = 1'b0; sz[w] = 2'b00; dad[w] = 32'h0; drv[w] = 32'h0;
        end
        apply_reset(3);
        checking = 1'b1;
        check("rst_ackd_n", {31'd0, ack0}, 32'd1);
        check("rst_align_err", {31'd0, aerr0}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Known contents for the random window 0x00..0x7F, with junk high address bits.
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 32; i++) begin
                xact(w, 1'b1, 2'b00, ($urandom & ~AMASK) | 32'(i * 4), $urandom, rd, lat);
            end
        end

        xact(0, 1'b1, 2'b00, 32'h0000_0040, 32'hDEAD_BEEF, rd, lat);
        check("st_latency", lat, 32'd3);
        xact(0, 1'b0, 2'b00, 32'h0000_0040, 32'h0, rd, lat);
        check("ld_latency", lat, 32'd3);
        check("ld_deadbeef", rd, 32'hDEAD_BEEF);

        for (int i = 0; i < 4; i++) begin
            xact(0, 1'b1, 2'b10, 32'h100 + 32'(i), 32'hFFFF_FF00 | 32'(8'h11 * (i + 1)), rd, lat);
        end
        xact(0, 1'b0, 2'b00, 32'h100, 32'h0, rd, lat);
        check("ld_bytes_word", rd, 32'h4433_2211);
        xact(0, 1'b0, 2'b10, 32'h102, 32'h0, rd, lat);
        check("ld_byte_102", rd, 32'h0000_0033);

        xact(0, 1'b1, 2'b00, 32'h200, 32'h0, rd, lat);
        xact(0, 1'b1, 2'b01, 32'h202, 32'h5555_ABCD, rd, lat);
        xact(0, 1'b0, 2'b00, 32'h200, 32'h0, rd, lat);
        check("ld_half_word", rd, 32'hABCD_0000);
        xact(0, 1'b0, 2'b01, 32'h202, 32'h0, rd, lat);
        check("ld_half_202", rd, 32'h0000_ABCD);

        // WAIT=0, MREQ held high across consecutive transactions.
        idle(1);
        for (int i = 0; i < 4; i++) begin
            xact(1, 1'b1, 2'b00, 32'h60 + 32'(4 * i), 32'hA0A0_0000 + 32'(i), rd, lat);
        end
        for (int i = 0; i < 4; i++) begin
            c0 = cyc;
            xact(1, 1'b0, 2'b00, 32'h60 + 32'(4 * i), 32'h0, rd, lat);
            acks[i] = c0 + lat;
            check("b2b_latency", lat, 32'd1);
            check("b2b_data", rd, 32'hA0A0_0000 + 32'(i));
            if (i > 0) check("b2b_ack_spacing", acks[i] - acks[i-1], 32'd2);
        end

        // Store abandoned by reset while WAITING.
        idle(1);
        xact(0, 1'b1, 2'b00, 32'h300, 32'hCAFE_F00D, rd, lat);
        idle(1);
        mreq[0] = 1'b1; wr[0] = 1'b1; sz[0] = 2'b00; dad[0] = 32'h300; drv[0] = 32'h1234_5678; oe[0] = 1'b1;
        $display("[TB] dut0 ST size=00 addr=00000300 data=12345678 aborted by reset");
        @(negedge clk);
        apply_reset(2);
        rst = 1'b1;
        @(negedge clk);
        xact(0, 1'b0, 2'b00, 32'h300, 32'h0, rd, lat);
        check("abort_kept_old", rd, 32'hCAFE_F00D);

        xact(0, 1'b1, 2'b00, 32'h400, 32'h5566_7788, rd, lat);
        xact(0, 1'b1, 2'b00, 32'h401, 32'h9ABC_DEF0, rd, lat);
        idle(2);
        check("misalign_flag", {31'd0, aerr0}, {31'd0, ALIGN_CHK});
        xact(0, 1'b0, 2'b00, 32'h400, 32'h0, rd, lat);
        check("misalign_store", rd, ALIGN_CHK ? 32'h5566_7788 : 32'h9ABC_DEF0);

        for (int i = 0; i < 300; i++) begin
            int w;
            w = $urandom_range(0, 1);
            xact(w, 1'($urandom), 2'($urandom), ($urandom & ~AMASK) | 32'($urandom_range(0, 127)),
                 $urandom, rd, lat);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end

        idle(2);
        apply_reset(2);
        check("final_rst_align_err", {31'd0, aerr0}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-side memory responder for the multicycle core's external data bus. It answers the core's MREQ/WRITE/SIZE/DAD requests, exchanges data on the bidirectional DDT bus, and signals completion with active-low ACKD_n after a configurable number of wait states. It holds a word-organised, byte-addressable little-endian RAM and sits outside the core, connected to the core's data-bus pins in the system testbench and FPGA top.

## Interface

- ADDR_W, default 12: word-address bits; RAM depth is 2^ADDR_W words (16 KiB at default).
- WAIT, default 2: wait cycles inserted between request acceptance and ACKD_n; legal range 0..15.

- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-low.
- MREQ  input  1  request valid; held high by the core until ACKD_n is sampled low.
- WRITE  input  1  1 = store, 0 = load; stable while MREQ is high.
- SIZE  input  2  00 = word, 01 = halfword, 10 = byte, 11 = reserved (treated as word).
- DAD  input  32  byte address; bits above ADDR_W+1 are ignored, so addresses wrap.
- DDT  inout  32  write data from the core (right-justified); read data to the core.
- ACKD_n  output  1  completion strobe, active-low, exactly one cycle per transaction.
- ALIGN_ERR  output  1  sticky misalignment flag (see Configuration).

## Operation

- FSM states: IDLE, WAITING, ACK.
- IDLE:
  - If MREQ=1, latch WRITE, SIZE, DAD and DDT (write data).
  - If WAIT>0, go to WAITING with the wait counter set to WAIT-1.
  - If WAIT=0, go directly to ACK.
- WAITING: decrement the counter; at 0, go to ACK.
- ACK:
  - ACKD_n=0.
  - Stores commit at the end of this cycle.
  - Loads drive DDT during this cycle.
  - Next state is IDLE.
- Byte lane = latched DAD[1:0]; halfword lane = DAD[1].
- Store data layout:
  - Byte: DDT[7:0] goes to the addressed byte.
  - Halfword: DDT[15:0] goes to the addressed halfword.
  - Word: DDT[31:0] goes to the whole word.
  - Other bytes in the word are unchanged (per-byte write enables).
- Load data is right-justified and zero-extended: byte in DDT[7:0], halfword in DDT[15:0]. The core performs sign extension.
- DDT tristate: the responder drives DDT only when state=ACK and the latched WRITE=0. It is high-Z in all other cycles, including during stores.
- Inputs are ignored outside IDLE; changes to DAD, SIZE or DDT mid-transaction have no effect.
- Back-to-back: if MREQ is high in the IDLE cycle following ACK, a new transaction is accepted.
- Reset values:
  - state=IDLE, ACKD_n=1, ALIGN_ERR=0, DDT high-Z.
  - RAM contents are not reset.
- Reset asserted mid-transaction: the transaction is abandoned, no store commits, and no ACK is issued.

## Timing

- Let cycle 0 be the IDLE cycle in which MREQ=1 is sampled.
- ACKD_n is low in cycle WAIT+1 only.
- Read data is valid on DDT in that same cycle.
- Latency from request to acknowledge is WAIT+1 cycles. Throughput is one transaction per WAIT+2 cycles.
- Store effects are visible to a load accepted in any later cycle.
- ACKD_n and DDT are driven from registered state, with no combinational path from MREQ.
- The RAM read is registered, using the latched address at acceptance or during WAITING, so data is ready by the ACK cycle (including when WAIT=0).

## Configuration

- MEM_ALIGN_CHECK_EN defined:
  - A halfword access with DAD[0]=1, or a word access with DAD[1:0]≠00, is misaligned.
  - Misaligned stores are suppressed.
  - Misaligned loads return 32'h0000_0000.
  - ACKD_n is still issued with normal timing.
  - ALIGN_ERR is set at the ACK cycle and stays 1 until reset.
- MEM_ALIGN_CHECK_EN undefined:
  - Ignored low address bits are forced to zero: DAD[0] for halfwords, DAD[1:0] for words.
  - The access proceeds at the aligned address.
  - ALIGN_ERR is tied to 0.

## Test plan

- WAIT=2: store word 0xDEADBEEF to 0x0000_0040, then load it.
  - ACKD_n is low in cycle 3 of each transaction.
  - The load returns 0xDEADBEEF on DDT.
  - DDT is high-Z in all other cycles.
- Byte stores 0x11, 0x22, 0x33, 0x44 to 0x100..0x103, then a word load from 0x100 returns 0x44332211. A byte load from 0x102 returns 0x0000_0033.
- Halfword store 0xABCD to 0x202 over word 0x00000000, then word load from 0x200 returns 0xABCD0000. Halfword load from 0x202 returns 0x0000ABCD.
- WAIT=0, back-to-back with MREQ held high across consecutive transactions: ACKD_n pulses every 2 cycles, and each load returns its own address's data.
- Store 0x12345678 to 0x300, with rst pulled low during WAITING. ACKD_n stays 1, and a later load from 0x300 returns the prior contents unchanged.
- Word store to 0x401:
  - With MEM_ALIGN_CHECK_EN: RAM is unchanged, ACKD_n is issued, and ALIGN_ERR=1 until reset.
  - Without MEM_ALIGN_CHECK_EN: the data lands at 0x400 and ALIGN_ERR=0.
